// File: rtl/matrix_writeback.sv
// matrix_writeback: captures a packed matrix result and serialises the active
// n x n (or single determinant) elements into byte-wide data memory, row-major,
// then reports done/error or enters a sticky halt on the end-of-program opcode.
module matrix_writeback #(
  parameter int ADDR_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0]                   opcode,
  input  logic [MAX_DIM*MAX_DIM*8-1:0] result,
  input  logic [7:0]                   matriz_size,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic                         mem_ready,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [7:0]                   mem_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         halted
);

  localparam int DATA_W = 8;
  localparam int RES_W  = MAX_DIM * MAX_DIM * DATA_W;
  localparam int CNT_W  = $clog2(MAX_DIM + 1);
  localparam int OFS_W  = $clog2(RES_W);
  localparam int LIN_W  = 2 * CNT_W + 1;

  localparam logic [2:0] OP_DET  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0] row, col, row_d, col_d;
  logic             err_q, err_d;
  logic             halt_ent_q, halt_ent_d;

  // Operands latched at start; the transfer never looks at the input ports again.
  logic [RES_W-1:0]  result_p0;
  logic [CNT_W-1:0]  size_p0;
  logic [ADDR_W-1:0] base_p0;
  logic              det_p0;

  logic                     capture;
  logic                     size_ok;
  logic                     col_end;
  logic                     last_elem;
  logic [OFS_W-1:0]         bit_ofs;
  logic [LIN_W-1:0]         lin;
  logic signed [DATA_W-1:0] elem;

  assign capture = (state == IDLE) && start;
  assign size_ok = (matriz_size >= 8'd2) && (matriz_size <= 8'(MAX_DIM));

  // The packed result always uses MAX_DIM-wide rows; memory uses n-wide rows.
  assign bit_ofs = OFS_W'(DATA_W) * (OFS_W'(row) * OFS_W'(MAX_DIM) + OFS_W'(col));
  assign elem    = result_p0[bit_ofs +: DATA_W];
  assign lin     = LIN_W'(row) * LIN_W'(size_p0) + LIN_W'(col);

  assign col_end   = (col == size_p0 - CNT_W'(1));
  // A determinant produces a single scalar stored at element (0,0).
  assign last_elem = det_p0 || (col_end && (row == size_p0 - CNT_W'(1)));

  // Capture stage: operand registers loaded only on an accepted start
  always_ff @(posedge clk) begin
    if (capture) begin
      result_p0 <= result;
      size_p0   <= matriz_size[CNT_W-1:0];
      base_p0   <= base_addr;
      det_p0    <= (opcode == OP_DET);
    end
  end

  // Control state: FSM state, element counters and pending flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      err_q      <= 1'b0;
      halt_ent_q <= 1'b0;
    end else begin
      state      <= state_d;
      row        <= row_d;
      col        <= col_d;
      err_q      <= err_d;
      halt_ent_q <= halt_ent_d;
    end
  end

  // Next-state, counter advance and output decode
  always_comb begin
    state_d    = state;
    row_d      = row;
    col_d      = col;
    err_d      = err_q;
    halt_ent_d = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    error      = 1'b0;
    halted     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          row_d = '0;
          col_d = '0;
          err_d = 1'b0;
          if (opcode == OP_HALT) begin
            state_d    = HALT;
            halt_ent_d = 1'b1;
          end else if (!size_ok) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = base_p0 + ADDR_W'(lin);
        mem_wdata = elem;
        if (mem_ready) begin
          if (last_elem) begin
            state_d = FINISH;
          end else if (col_end) begin
            col_d = '0;
            row_d = row + CNT_W'(1);
          end else begin
            col_d = col + CNT_W'(1);
          end
        end
      end

      FINISH: begin
        done    = 1'b1;
        error   = err_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end

      HALT: begin
        halted = 1'b1;
        done   = halt_ent_q;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_writeback.sv
// Directed bench for matrix_writeback: hand-computed expectations for each
// scenario, immediate assertions at every comparison point.
module tb_matrix_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   opcode;
  logic [199:0] result;
  logic [7:0]   matriz_size;
  logic [7:0]   base_addr;
  logic         mem_ready;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_wdata;
  logic         busy;
  logic         done;
  logic         error;
  logic         halted;

  int n_checks = 0;
  int n_fail   = 0;

  // write log filled by the memory-side monitor
  logic [7:0] wr_addr [0:511];
  logic [7:0] wr_data [0:511];
  int         wr_n       = 0;
  int         we_cycles  = 0;
  int         done_cnt   = 0;
  logic       err_at_done;

  matrix_writeback #(.ADDR_W(8), .MAX_DIM(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .result      (result),
    .matriz_size (matriz_size),
    .base_addr   (base_addr),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: sample mid-cycle, log every accepted write
  always @(negedge clk) begin
    if (mem_we) we_cycles <= we_cycles + 1;
    if (mem_we && mem_ready) begin
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_n          <= wr_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] put(input logic [199:0] r, input int idx, input logic [7:0] v);
    logic [199:0] t;
    t = r;
    t[8*idx +: 8] = v;
    return t;
  endfunction

  // Present a start request in the current cycle (cycle 0).
  task automatic start_op(input logic [2:0] op, input logic [7:0] n,
                          input logic [7:0] base, input logic [199:0] res);
    opcode      = op;
    matriz_size = n;
    base_addr   = base;
    result      = res;
    start       = 1'b1;
  endtask

  // Advance cycle by cycle until done; optionally toggle mem_ready and
  // verify that the presented write holds steady across each stall.
  task automatic run_op(input int budget, input bit toggle, output int done_cyc);
    logic [7:0] hold_a;
    logic [7:0] hold_d;
    bit         hold_v;
    hold_v   = 1'b0;
    hold_a   = '0;
    hold_d   = '0;
    done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      step();
      start = 1'b0;
      if (toggle) mem_ready = (c % 2 == 0);
      if (c == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (hold_v) begin
        check("stall_addr", 32'(mem_addr), 32'(hold_a));
        check("stall_data", 32'(mem_wdata), 32'(hold_d));
        hold_v = 1'b0;
      end
      if (toggle && !mem_ready && mem_we) begin
        hold_a = mem_addr;
        hold_d = mem_wdata;
        hold_v = 1'b1;
      end
      if (done) begin
        done_cyc    = c;
        err_at_done = error;
        break;
      end
    end
  endtask

  initial begin
    int           dcyc;
    int           w0, e0, d0;
    logic [199:0] r;

    reset       = 1'b1;
    start       = 1'b0;
    opcode      = 3'b000;
    result      = '0;
    matriz_size = 8'd0;
    base_addr   = 8'd0;
    mem_ready   = 1'b1;
    err_at_done = 1'b0;

    // ---- reset state ----
    step();
    step();
    check("rst_ctrl", 32'({mem_we, busy, done, error, halted}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    step();

    // ---- 3x3 add: data 1..9 to 0x10..0x18, done at cycle 10 ----
    r = {25{8'hAA}};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        r = put(r, 5*i + j, 8'(3*i + j + 1));
    w0 = wr_n; e0 = we_cycles;
    start_op(3'b000, 8'd3, 8'h10, r);
    run_op(40, 1'b0, dcyc);
    check("add3_done_cycle", 32'(dcyc), 32'd10);
    check("add3_error", 32'(err_at_done), 32'd0);
    check("add3_we_cycles", 32'(we_cycles - e0), 32'd9);
    check("add3_nwrites", 32'(wr_n - w0), 32'd9);
    for (int k = 0; k < 9; k++) begin
      check("add3_addr", 32'(wr_addr[w0 + k]), 32'(8'h10 + k));
      check("add3_data", 32'(wr_data[w0 + k]), 32'(k + 1));
    end
    step();
    check("add3_idle", 32'({busy, done}), 32'd0);

    // ---- determinant: single 0xF6 write, done 2 cycles after start ----
    r = {25{8'h01}};
    r = put(r, 0, 8'hF6);
    w0 = wr_n;
    start_op(3'b110, 8'd4, 8'h30, r);
    run_op(20, 1'b0, dcyc);
    check("det_done_cycle", 32'(dcyc), 32'd2);
    check("det_error", 32'(err_at_done), 32'd0);
    check("det_nwrites", 32'(wr_n - w0), 32'd1);
    check("det_addr", 32'(wr_addr[w0]), 32'h30);
    check("det_data", 32'(wr_data[w0]), 32'hF6);
    step();

    // ---- backpressure: 2x2, ready toggling 0,1,0,1 ----
    r = {25{8'hEE}};
    r = put(r, 0, 8'h11);
    r = put(r, 1, 8'h22);
    r = put(r, 5, 8'h33);
    r = put(r, 6, 8'h44);
    w0 = wr_n; e0 = we_cycles;
    mem_ready = 1'b0;
    start_op(3'b001, 8'd2, 8'h40, r);
    run_op(30, 1'b1, dcyc);
    check("bp_done_cycle", 32'(dcyc), 32'd9);
    check("bp_nwrites", 32'(wr_n - w0), 32'd4);
    check("bp_we_cycles", 32'(we_cycles - e0), 32'd8);
    check("bp_addr0", 32'(wr_addr[w0]), 32'h40);
    check("bp_addr3", 32'(wr_addr[w0 + 3]), 32'h43);
    check("bp_data0", 32'(wr_data[w0]), 32'h11);
    check("bp_data1", 32'(wr_data[w0 + 1]), 32'h22);
    check("bp_data2", 32'(wr_data[w0 + 2]), 32'h33);
    check("bp_data3", 32'(wr_data[w0 + 3]), 32'h44);
    mem_ready = 1'b1;
    step();

    // ---- invalid size n=6: no writes, done+error one cycle after start ----
    w0 = wr_n; e0 = we_cycles;
    start_op(3'b001, 8'd6, 8'h50, r);
    run_op(10, 1'b0, dcyc);
    check("inv_done_cycle", 32'(dcyc), 32'd1);
    check("inv_error", 32'(err_at_done), 32'd1);
    step();
    check("inv_after", 32'({busy, done, error}), 32'd0);
    check("inv_no_we", 32'(we_cycles - e0), 32'd0);

    // ---- 5x5 at base 0xF0: address wraps 0xFF -> 0x00 .. 0x08 ----
    r = '0;
    for (int k = 0; k < 25; k++) r = put(r, k, 8'(8'h60 + k));
    w0 = wr_n;
    start_op(3'b000, 8'd5, 8'hF0, r);
    run_op(60, 1'b0, dcyc);
    check("wrap_done_cycle", 32'(dcyc), 32'd26);
    check("wrap_nwrites", 32'(wr_n - w0), 32'd25);
    check("wrap_addr_ff", 32'(wr_addr[w0 + 15]), 32'hFF);
    check("wrap_addr_00", 32'(wr_addr[w0 + 16]), 32'h00);
    check("wrap_addr_08", 32'(wr_addr[w0 + 24]), 32'h08);
    for (int k = 0; k < 25; k++)
      check("wrap_data", 32'(wr_data[w0 + k]), 32'(8'h60 + k));
    step();

    // ---- halt: one done pulse, sticky halted, start ignored until reset ----
    w0 = wr_n; d0 = done_cnt;
    start_op(3'b111, 8'd3, 8'h00, r);
    run_op(10, 1'b0, dcyc);
    check("halt_done_cycle", 32'(dcyc), 32'd1);
    check("halt_flag", 32'(halted), 32'd1);
    step();
    step();
    check("halt_done_once", 32'(done), 32'd0);
    start_op(3'b000, 8'd2, 8'h20, r);
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("halt_held", 32'({halted, busy}), 32'h3);
    check("halt_no_writes", 32'(wr_n - w0), 32'd0);
    check("halt_done_count", 32'(done_cnt - d0), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("halt_cleared", 32'({halted, busy}), 32'd0);
    step();

    // ---- reset after the 3rd write of a 5x5 transfer ----
    w0 = wr_n; d0 = done_cnt;
    mem_ready = 1'b1;
    start_op(3'b000, 8'd5, 8'h00, r);
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("rstmid_three_writes", 32'(wr_n - w0), 32'd3);
    reset     = 1'b1;
    mem_ready = 1'b0;
    step();
    check("rstmid_ctrl", 32'({mem_we, busy, done, error, halted}), 32'd0);
    check("rstmid_addr", 32'(mem_addr), 32'd0);
    check("rstmid_data", 32'(mem_wdata), 32'd0);
    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("rstmid_no_more", 32'(wr_n - w0), 32'd3);
    check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

    // ---- start together with reset: reset wins ----
    e0 = we_cycles;
    reset = 1'b1;
    start_op(3'b000, 8'd2, 8'h00, r);
    step();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_idle", 32'({busy, mem_we}), 32'd0);
    step();
    step();
    check("rst_start_no_we", 32'(we_cycles - e0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
